// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: instruction geometry and the fetch queue entry layout.
package cpu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam int unsigned INST_BYTES   = 4;
    localparam logic [XLEN_DEFAULT-1:0] NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] inst;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {inst, pc} pairs; flush empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push_i && (count_q != CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Prefetching fetch stage: credit-limited in-order memory requests, a decoupling queue to decode,
// and redirect handling that flushes the queue and drops stale in-flight responses.
module fetch_prefetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);

    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     drop_q, drop_d;
    logic              err_q, err_d;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic [31:0]       occupancy;
    logic [XLEN-1:0]   redir_pc;
    logic              issue, rsp_ok, push, pop;

    // Queue slots already spoken for: buffered words plus live (non-stale) requests.
    assign occupancy = 32'(count) + 32'(outst_q - drop_q);
    assign req_valid = !reset && !redirect_valid && (occupancy < DEPTH)
                       && (32'(outst_q) < MAX_OUTST);
    assign req_addr  = pc_q;

    assign redir_pc = redirect_pc & ~XLEN'(3);
    assign issue    = req_valid && req_ready;
    assign rsp_ok   = rsp_valid && (outst_q != '0);
    assign push     = rsp_ok && (drop_q == '0) && !redirect_valid;
    assign pop      = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        pc_d     = pc_q;
        rsp_pc_d = rsp_pc_q;
        drop_d   = drop_q;
        outst_d  = outst_q + OW'(issue) - OW'(rsp_ok);
        err_d    = err_q | (rsp_valid && (outst_q == '0));
        if (redirect_valid) begin
            pc_d     = redir_pc;
            rsp_pc_d = redir_pc;
            drop_d   = outst_q - OW'(rsp_ok);
        end else begin
            if (issue) pc_d = pc_q + XLEN'(INST_BYTES);
            if (push)  rsp_pc_d = rsp_pc_q + XLEN'(INST_BYTES);
            if (rsp_ok && (drop_q != '0)) drop_d = drop_q - OW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            outst_q  <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            rsp_pc_q <= rsp_pc_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i ({rsp_data, rsp_pc_q}),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .head_o      (head),
        .count_o     (count)
    );

    assign inst_valid = (count != '0);
    assign inst       = head[2*XLEN-1:XLEN];
    assign inst_pc    = head[XLEN-1:0];
    assign err        = err_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: fixed-latency memory model plus an issue-order scoreboard.
module tb_fetch_prefetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst, inst_pc;
    logic        err;

    always #5 clk = ~clk;

    fetch_prefetch_unit #(
        .XLEN      (32),
        .DEPTH     (4),
        .MAX_OUTST (4),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .err            (err)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t        lat_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  iss_log[$];
    logic [31:0]  deq_log[$];
    int           lat = 1;
    int           cyc = 0;
    int           nchecks = 0;
    int           nerrors = 0;
    logic         spur = 1'b0;
    logic         o_req_valid, o_inst_valid, o_rsp;
    int           n0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the negedge, observe 1ns later, then advance to the next negedge.
    task automatic tick(input logic rq, input logic ir, input logic rd, input logic [31:0] rpc);
        fetch_entry_t e;
        req_ready      = rq;
        inst_ready     = ir;
        redirect_valid = rd;
        redirect_pc    = rpc;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        if (spur) begin
            rsp_valid = 1'b1;
            rsp_data  = 32'hDEAD_BEEF;
        end else if (lat_q.size() > 0 && lat_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = lat_q[0].addr + 32'd100;
        end
        #1;
        o_req_valid  = req_valid;
        o_inst_valid = inst_valid;
        o_rsp        = rsp_valid;
        if (rsp_valid && !spur) lat_q.delete(0);
        if (inst_valid && inst_ready && !redirect_valid) begin
            deq_log.push_back(inst_pc);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_inst", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_inst_pc", inst_pc, e.pc);
                check("sb_inst", inst, e.inst);
            end
        end
        if (redirect_valid) exp_q.delete();
        if (req_valid && req_ready) begin
            exp_q.push_back('{inst: req_addr + 32'd100, pc: req_addr});
            iss_log.push_back(req_addr);
            lat_q.push_back('{addr: req_addr, due: cyc + lat});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_model();
        lat_q.delete();
        exp_q.delete();
        iss_log.delete();
        deq_log.delete();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        req_ready      = 1'b0;
        inst_ready     = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        spur           = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        reset          = 1'b1;
        req_ready      = 1'b0;
        inst_ready     = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk);
        #1;
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_err", 32'(err), 32'd0);

        // 1: streaming with 1-cycle memory
        do_reset();
        lat = 1;
        tick(1'b1, 1'b1, 1'b0, '0);
        check("t1_first_req_valid", 32'(o_req_valid), 32'd1);
        check("t1_c0_inst_valid", 32'(o_inst_valid), 32'd0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("t1_c1_rsp", 32'(o_rsp), 32'd1);
        check("t1_no_bypass", 32'(o_inst_valid), 32'd0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("t1_latency", 32'(o_inst_valid), 32'd1);
        repeat (5) tick(1'b1, 1'b1, 1'b0, '0);
        check("t1_n_iss", 32'(iss_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check("t1_req_addr", iss_log[i], 32'(i * 4));
        check("t1_first_deq", deq_log[0], 32'h0);

        // 2: decode stalled fills exactly DEPTH, then drains
        do_reset();
        lat = 1;
        repeat (10) tick(1'b1, 1'b0, 1'b0, '0);
        check("t2_n_issued", 32'(iss_log.size()), 32'd4);
        check("t2_stalled", 32'(o_req_valid), 32'd0);
        check("t2_full_valid", 32'(inst_valid), 32'd1);
        repeat (12) tick(1'b1, 1'b1, 1'b0, '0);
        check("t2_n_deq", 32'(deq_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check("t2_drain_pc", deq_log[i], 32'(i * 4));
        check("t2_n_iss_resume", 32'(iss_log.size() >= 5), 32'd1);
        check("t2_resume_addr", iss_log[4], 32'h10);

        // 3: redirect with three requests in flight on 3-cycle memory
        do_reset();
        lat = 3;
        repeat (3) tick(1'b1, 1'b1, 1'b0, '0);
        deq_log.delete();
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        check("t3_no_issue_on_redir", 32'(o_req_valid), 32'd0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("t3_flushed", 32'(o_inst_valid), 32'd0);
        for (int i = 0; i < 20 && deq_log.size() == 0; i++) tick(1'b1, 1'b1, 1'b0, '0);
        check("t3_got_inst", 32'(deq_log.size() > 0), 32'd1);
        check("t3_first_pc", deq_log[0], 32'h200);
        repeat (6) tick(1'b1, 1'b1, 1'b0, '0);

        // 4: redirect colliding with a response and a pop, unaligned target
        do_reset();
        lat = 2;
        repeat (6) tick(1'b1, 1'b1, 1'b0, '0);
        deq_log.delete();
        n0 = iss_log.size();
        tick(1'b1, 1'b1, 1'b1, 32'h303);
        check("t4_rsp_present", 32'(o_rsp), 32'd1);
        check("t4_head_present", 32'(o_inst_valid), 32'd1);
        check("t4_no_issue_on_redir", 32'(o_req_valid), 32'd0);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("t4_flushed", 32'(o_inst_valid), 32'd0);
        check("t4_restart_issued", 32'(iss_log.size() > n0), 32'd1);
        check("t4_restart_addr", iss_log[n0], 32'h300);
        tick(1'b1, 1'b1, 1'b0, '0);
        check("t4_stale_dropped", 32'(o_inst_valid), 32'd0);
        repeat (6) tick(1'b1, 1'b1, 1'b0, '0);
        check("t4_n_deq", 32'(deq_log.size() > 0), 32'd1);
        check("t4_first_pc", deq_log[0], 32'h300);

        // 5: memory backpressure, then a spurious response sets sticky err
        do_reset();
        lat = 1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, '0);
            check("t5_req_valid_held", 32'(o_req_valid), 32'd1);
            check("t5_addr_stable", req_addr, 32'h0);
        end
        check("t5_err_before", 32'(err), 32'd0);
        spur = 1'b1;
        tick(1'b0, 1'b1, 1'b0, '0);
        spur = 1'b0;
        check("t5_err_set", 32'(err), 32'd1);
        check("t5_spur_not_queued", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b1, 1'b0, '0);
            check("t5_err_sticky", 32'(err), 32'd1);
        end
        repeat (4) tick(1'b1, 1'b1, 1'b0, '0);
        do_reset();
        #1;
        check("t5_err_cleared", 32'(err), 32'd0);

        // 6: asynchronous reset with a full queue
        lat = 1;
        repeat (8) tick(1'b1, 1'b0, 1'b0, '0);
        check("t6_queue_full", 32'(inst_valid), 32'd1);
        #3;
        reset = 1'b1;
        #1;
        check("t6_req_valid", 32'(req_valid), 32'd0);
        check("t6_inst_valid", 32'(inst_valid), 32'd0);
        check("t6_inst", inst, 32'd0);
        check("t6_inst_pc", inst_pc, 32'd0);
        check("t6_err", 32'(err), 32'd0);
        @(negedge clk);
        do_reset();
        tick(1'b1, 1'b1, 1'b0, '0);
        check("t6_issued", 32'(iss_log.size()), 32'd1);
        check("t6_first_addr", iss_log[0], 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
